// File: rtl/aes_key_expand_pkg.sv
// rtl/aes_key_expand_pkg.sv - shared constants, lookups and GF(2^8) helpers for the AES key schedule
//
// Package aes_pkg:
//   KEY_LEN_*        key_len encodings (00=128, 01=192, 10=256, 11 reserved)
//   ke_state_e       key-expansion FSM states
//   nk_of / nr_of    key words and round count for a key_len code
//   xtime            multiply by x in GF(2^8), 0x1b reduction
//   inv_mix_column   InvMixColumns on one 32-bit column (decrypt-key reads)
package aes_pkg;

  localparam logic [1:0] KEY_LEN_128  = 2'b00;
  localparam logic [1:0] KEY_LEN_192  = 2'b01;
  localparam logic [1:0] KEY_LEN_256  = 2'b10;
  localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_SUB  = 2'd2
  } ke_state_e;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KEY_LEN_192: nk_of = 4'd6;
      KEY_LEN_256: nk_of = 4'd8;
      default:     nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    nr_of = nk_of(kl) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multipliers 09/0b/0d/0e are built from the x2/x4/x8 chain of each byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = w[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    inv_mix_column = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                      m9[0] ^ me[1] ^ mb[2] ^ md[3],
                      md[0] ^ m9[1] ^ me[2] ^ mb[3],
                      mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// rtl/aes_key_expand_if.sv - start handshake, status and round-key read bus of aes_key_expand
//
// Signals: start, key_len[1:0], key_i[255:0] (request side), busy, done, keys_valid (status),
// rk_rd_round[3:0] -> rk_rd_data[127:0] (registered read port).
// AES_KEY_EXPAND_DEC_EN adds rk_rd_inv (select InvMixColumns round key on read).
// Modports: master = requester / round datapath, slave = key expander.
interface aes_key_expand_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_i;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_rd_round;
  logic [127:0] rk_rd_data;
`ifdef AES_KEY_EXPAND_DEC_EN
  logic         rk_rd_inv;
`endif

  modport master (
    output start, key_len, key_i, rk_rd_round,
`ifdef AES_KEY_EXPAND_DEC_EN
    output rk_rd_inv,
`endif
    input  busy, done, keys_valid, rk_rd_data
  );

  modport slave (
    input  start, key_len, key_i, rk_rd_round,
`ifdef AES_KEY_EXPAND_DEC_EN
    input  rk_rd_inv,
`endif
    output busy, done, keys_valid, rk_rd_data
  );
endinterface

// File: rtl/aes_key_expand_sub_word.sv
// rtl/aes_key_expand_sub_word.sv - registered SubWord: four forward AES S-boxes, 1-cycle latency
//
// aes_sbox:     clk, in_byte[7:0] -> out_byte[7:0] (registered)
// aes_sub_word: clk, word_i[31:0] -> word_o[31:0]  (registered, byte-wise S-box)
module aes_sbox (
  input  logic       clk,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Entry for byte value v sits at bits [2047-8v -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_lo;
  assign bit_lo = 11'd2040 - {in_byte, 3'b000};

  always_ff @(posedge clk) begin
    out_byte <= SBOX[bit_lo +: 8];
  end
endmodule

module aes_sub_word (
  input  logic        clk,
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .clk      (clk),
      .in_byte  (word_i[8*g +: 8]),
      .out_byte (word_o[8*g +: 8])
    );
  end
endmodule

// File: rtl/aes_key_expand.sv
// rtl/aes_key_expand.sv - iterative word-serial AES-128/192/256 key schedule with round-key store
//
// Ports: clk, rst_n (async active-low), bus (aes_key_expand_if.slave):
//   start/key_len/key_i request, busy/done/keys_valid status,
//   rk_rd_round -> rk_rd_data registered 128-bit round-key read.
// Parameter MAX_NK: largest key in words (4, 6 or 8); store depth 4*(MAX_NK+7).
// Macro AES_KEY_EXPAND_DEC_EN: rk_rd_inv=1 returns InvMixColumns of rounds 1..Nr-1.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input logic            clk,
  input logic            rst_n,
  aes_key_expand_if.slave bus
);
  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW    = $clog2(DEPTH);
  localparam int HW    = $clog2(MAX_NK);

  ke_state_e    state_q, state_d;
  logic [5:0]   i_q;          // index of the word being produced
  logic [3:0]   j_q;          // i_q mod Nk, avoids a divider
  logic [3:0]   nk_q, nr_q;
  logic [7:0]   rcon_q;
  logic         done_q, keys_valid_q;
  logic [127:0] rd_data_q;

  // hist_q[0] = w[i-1] ... hist_q[Nk-1] = w[i-Nk]
  logic [31:0]  hist_q [MAX_NK];
  logic [31:0]  mem    [DEPTH];
  logic [31:0]  kw     [8];

  logic         accept;
  logic [3:0]   nk_req;
  logic [5:0]   last_idx;
  logic         last_word, rot_step, sub_step;
  logic [HW-1:0] back_idx;
  logic [31:0]  w_prev, w_back, sbox_in, sbox_out, temp, new_word;
  logic         wr_en, finish;
  logic [127:0] rd_raw, rd_next;

  always_comb begin
    for (int k = 0; k < 8; k++) kw[k] = bus.key_i[255-32*k -: 32];
  end

  assign nk_req = nk_of(bus.key_len);
  assign accept = bus.start && (state_q == ST_IDLE) &&
                  (bus.key_len != KEY_LEN_RSVD) && (nk_req <= 4'(MAX_NK));

  assign last_idx  = {nr_q, 2'b11};
  assign last_word = (i_q == last_idx);
  assign back_idx  = HW'(nk_q - 4'd1);
  assign w_prev    = hist_q[0];
  assign w_back    = hist_q[back_idx];
  assign rot_step  = (j_q == 4'd0);
  assign sub_step  = rot_step || ((nk_q == 4'd8) && (j_q == 4'd4));
  // S-box input is launched every cycle; it is only consumed in SUB, where hist_q is stable.
  assign sbox_in   = rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .clk    (clk),
    .word_i (sbox_in),
    .word_o (sbox_out)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_GEN;
      ST_GEN: begin
        if (sub_step)       state_d = ST_SUB;
        else if (last_word) state_d = ST_IDLE;
      end
      ST_SUB:  state_d = last_word ? ST_IDLE : ST_GEN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr_en = 1'b0;
    temp  = w_prev;
    case (state_q)
      ST_GEN: wr_en = !sub_step;
      ST_SUB: begin
        wr_en = 1'b1;
        temp  = sbox_out ^ (rot_step ? {rcon_q, 24'h0} : 32'h0);
      end
      default: ;
    endcase
    new_word = w_back ^ temp;
    finish   = wr_en && last_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q          <= '0;
      j_q          <= '0;
      nk_q         <= 4'd4;
      nr_q         <= 4'd10;
      rcon_q       <= 8'h01;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        nk_q         <= nk_req;
        nr_q         <= nr_of(bus.key_len);
        i_q          <= 6'(nk_req);
        j_q          <= 4'd0;
        rcon_q       <= 8'h01;
        keys_valid_q <= 1'b0;
      end else if (wr_en) begin
        i_q <= i_q + 6'd1;
        j_q <= (j_q == nk_q - 4'd1) ? 4'd0 : j_q + 4'd1;
        if (rot_step) rcon_q <= xtime(rcon_q);
        if (finish)   keys_valid_q <= 1'b1;
      end
    end
  end

  // Storage and history carry no reset: their contents are don't-care until a run loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (4'(k) < nk_req) mem[k] <= kw[k];
        // Entries at or beyond Nk pick up unused words; they are never read as w[i-Nk].
        hist_q[k] <= kw[3'(nk_req - 4'd1 - 4'(k))];
      end
    end else if (wr_en) begin
      mem[AW'(i_q)] <= new_word;
      for (int k = MAX_NK - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
      hist_q[0] <= new_word;
    end
  end

  always_comb begin
    rd_raw  = {mem[AW'({bus.rk_rd_round, 2'd0})], mem[AW'({bus.rk_rd_round, 2'd1})],
               mem[AW'({bus.rk_rd_round, 2'd2})], mem[AW'({bus.rk_rd_round, 2'd3})]};
    rd_next = (bus.rk_rd_round > nr_q) ? 128'h0 : rd_raw;
`ifdef AES_KEY_EXPAND_DEC_EN
    if (bus.rk_rd_inv && (bus.rk_rd_round != 4'd0) && (bus.rk_rd_round < nr_q)) begin
      rd_next = {inv_mix_column(rd_raw[127:96]), inv_mix_column(rd_raw[95:64]),
                 inv_mix_column(rd_raw[63:32]),  inv_mix_column(rd_raw[31:0])};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_next;
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_rd_data = rd_data_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb/tb_aes_key_expand.sv - self-checking bench for aes_key_expand against a FIPS-197 style reference
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_key_expand_if bus ();

  aes_key_expand #(.MAX_NK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] key;
    int           round;
    logic [127:0] exp;
    int           len;
  } vec_t;
  vec_t vecs [4];

  logic [7:0]  sbox_ref [256];
  logic [31:0] ref_w    [60];
  int          ref_nr;
  int          ref_cycles;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] y;
    y = {x, x} << n;
    return y[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  function automatic logic [31:0] inv_mix_ref(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic int nk_of_len(input logic [1:0] kl);
    return (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
  endfunction

  // Full schedule plus expected busy length (1 cycle per plain word, 2 per SubWord word).
  task automatic ref_expand(input logic [255:0] key, input int nk);
    logic [7:0]  rc;
    logic [31:0] t;
    ref_nr     = nk + 6;
    ref_cycles = 0;
    rc         = 8'h01;
    for (int i = 0; i < nk; i++) ref_w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (ref_nr + 1); i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        t = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
        ref_cycles += 2;
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word_ref(t);
        ref_cycles += 2;
      end else begin
        ref_cycles += 1;
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_round(input int r);
    if (r > ref_nr) return 128'h0;
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic do_run(input logic [1:0] kl, input logic [255:0] key, input bit poke,
                        output int cycles);
    @(negedge clk);
    bus.key_len = kl;
    bus.key_i   = key;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", 256'(bus.busy), 256'(1));
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      if (poke && cycles == 10) begin
        bus.start   = 1'b1;
        bus.key_i   = ~key;
        bus.key_len = 2'b00;
      end
      if (poke && cycles == 12) begin
        bus.start   = 1'b0;
        bus.key_i   = key;
        bus.key_len = kl;
      end
      cycles++;
      @(negedge clk);
    end
    check("done_at_busy_fall", 256'(bus.done), 256'(1));
    check("keys_valid_at_busy_fall", 256'(bus.keys_valid), 256'(1));
    @(negedge clk);
    check("done_one_cycle", 256'(bus.done), 256'(0));
  endtask

  task automatic read_round(input int r, output logic [127:0] d);
    @(negedge clk);
    bus.rk_rd_round = 4'(r);
    @(negedge clk);
    d = bus.rk_rd_data;
  endtask

  initial begin
    int           cyc;
    int           nk;
    logic [1:0]   kl;
    logic [255:0] key;
    logic [127:0] d;

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.key_len     = 2'b00;
    bus.key_i       = '0;
    bus.rk_rd_round = 4'd0;
`ifdef AES_KEY_EXPAND_DEC_EN
    bus.rk_rd_inv   = 1'b0;
`endif

    vecs[0] = '{2'b00, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605, 50};
    vecs[1] = '{2'b00, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 50};
    vecs[2] = '{2'b01, K192, 12, 128'he98ba06f448c773c8ecc720401002202, 54};
    vecs[3] = '{2'b10, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e, 65};

    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_busy",       256'(bus.busy),       256'(0));
    check("reset_done",       256'(bus.done),       256'(0));
    check("reset_keys_valid", 256'(bus.keys_valid), 256'(0));
    check("reset_rk_rd_data", 256'(bus.rk_rd_data), 256'(0));
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      do_run(vecs[v].kl, vecs[v].key, 1'b0, cyc);
      check("vec_busy_len", 256'(cyc), 256'(vecs[v].len));
      read_round(vecs[v].round, d);
      check("vec_round_key", 256'(d), 256'(vecs[v].exp));
      ref_expand(vecs[v].key, nk_of_len(vecs[v].kl));
      check("vec_ref_model", 256'(ref_round(vecs[v].round)), 256'(vecs[v].exp));
    end

    // start pulsed mid-run with a different key and length must not disturb the result
    do_run(2'b00, K128, 1'b1, cyc);
    check("poke_busy_len", 256'(cyc), 256'(50));
    read_round(1, d);
    check("poke_round1", 256'(d), 256'(vecs[0].exp));
    read_round(10, d);
    check("poke_round10", 256'(d), 256'(vecs[1].exp));
    read_round(11, d);
    check("round11_after_128", 256'(d), 256'(0));

    // reserved key_len is ignored
    @(negedge clk);
    bus.key_len = 2'b11;
    bus.key_i   = K256;
    bus.start   = 1'b1;
    @(negedge clk);
    check("rsvd_busy", 256'(bus.busy), 256'(0));
    check("rsvd_keys_valid", 256'(bus.keys_valid), 256'(1));
    bus.start = 1'b0;
    @(negedge clk);
    check("rsvd_busy_later", 256'(bus.busy), 256'(0));
    read_round(1, d);
    check("rsvd_round1_kept", 256'(d), 256'(vecs[0].exp));

    // randomized keys against the reference schedule
    for (int n = 0; n < 6; n++) begin
      kl  = 2'($urandom_range(0, 2));
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      nk  = nk_of_len(kl);
      ref_expand(key, nk);
      do_run(kl, key, 1'b0, cyc);
      check("rand_busy_len", 256'(cyc), 256'(ref_cycles));
      for (int r = 0; r <= ref_nr + 1; r++) begin
        read_round(r, d);
        check("rand_round_key", 256'(d), 256'(ref_round(r)));
      end
    end

    // reset in the middle of a 256-bit run
    @(negedge clk);
    bus.key_len = 2'b10;
    bus.key_i   = K256;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("midrun_busy_before_reset", 256'(bus.busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy",       256'(bus.busy),       256'(0));
    check("midrun_reset_done",       256'(bus.done),       256'(0));
    check("midrun_reset_keys_valid", 256'(bus.keys_valid), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(2'b00, K128, 1'b0, cyc);
    check("post_reset_busy_len", 256'(cyc), 256'(50));
    read_round(1, d);
    check("post_reset_round1", 256'(d), 256'(vecs[0].exp));
    read_round(10, d);
    check("post_reset_round10", 256'(d), 256'(vecs[1].exp));

`ifdef AES_KEY_EXPAND_DEC_EN
    ref_expand(K128, 4);
    bus.rk_rd_inv = 1'b1;
    read_round(1, d);
    check("inv_round1", 256'(d), 256'({inv_mix_ref(ref_w[4]), inv_mix_ref(ref_w[5]),
                                       inv_mix_ref(ref_w[6]), inv_mix_ref(ref_w[7])}));
    read_round(0, d);
    check("inv_round0_plain", 256'(d), 256'(ref_round(0)));
    read_round(10, d);
    check("inv_round10_plain", 256'(d), 256'(ref_round(10)));
    bus.rk_rd_inv = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative, word-serial AES key schedule supporting 128/192/256-bit keys selected per run. It accepts a cipher key on a start handshake, generates every round-key word with one shared SubWord unit, and stores the schedule in an internal word array. The round datapath reads 128-bit round keys from that array through a registered read port. It replaces the fixed single-round AES-128 key step in the encryption pipeline.

## Interface
- MAX_NK, default 8: largest supported key length in 32-bit words (4, 6 or 8); storage depth = 4*(MAX_NK+7) words.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to expand key_i; accepted only when busy=0.
- key_len  in  2  2'b00=128, 2'b01=192, 2'b10=256; 2'b11 reserved.
- key_i  in  256  cipher key, word w0 at [255:224]; 128-bit keys use [255:128], 192-bit keys use [255:64].
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the last word is written.
- keys_valid  out  1  schedule complete and readable; held until the next accepted start or reset.
- rk_rd_round  in  4  round index to read.
- rk_rd_data  out  128  round key, words w[4r]..w[4r+3], with w[4r] at [127:96].

## Operation
- Nk = 4/6/8 and Nr = 10/12/14 for key_len 00/01/10. Nk must be <= MAX_NK.
- A start is accepted when busy=0, key_len is not 11, and Nk <= MAX_NK. Any other start is ignored with no state change.
- FSM states:
  - IDLE: on acceptance, write w0..w(Nk-1) into storage and the Nk-deep history register, set rcon=8'h01, i=Nk, clear keys_valid, go to GEN.
  - GEN: compute temp = w[i-1].
    - If i%Nk==0, or Nk==8 and i%8==4, issue SubWord (S-box input already rotated when i%Nk==0) and go to SUB.
    - Otherwise write w[i] = w[i-Nk]^temp and increment i.
  - SUB: form temp = SubWord(RotWord(w[i-1]))^{rcon,24'h0} for i%Nk==0, or SubWord(w[i-1]) for the 256-bit i%8==4 case. Write w[i] = w[i-Nk]^temp, increment i, return to GEN.
  - Rcon advance: after each i%Nk==0 word, rcon = xtime(rcon), with 0x1b reduction on bit-7 carry.
  - Completion: after writing w[4*(Nr+1)-1], go to IDLE, pulse done, set keys_valid.
- Read port: rk_rd_data is registered from storage. A round index > Nr of the current/last key_len returns 128'h0. Reads during busy return the stored words with no validity guarantee; keys_valid=0 flags this.
- Reset (including mid-expansion): FSM to IDLE, all status outputs cleared, storage contents don't-care.

## Timing
- Reset values: busy=0, done=0, keys_valid=0, rk_rd_data=0.
- busy rises the cycle after the accepting edge and stays high exactly L cycles: L=50 (128), 54 (192), 65 (256). Each plain word costs 1 cycle; each SubWord word costs 2 cycles because the S-box is registered with 1-cycle latency.
- done and the keys_valid rise occur in the same cycle that busy falls.
- start is accepted on the same edge that busy falls? No: start is ignored while busy=1 and can be accepted no earlier than the cycle in which busy=0.
- Read latency is 1 cycle: rk_rd_round sampled at edge N gives data after edge N.

## Configuration
- AES_KEY_EXPAND_DEC_EN defined: adds input rk_rd_inv (1 bit). When rk_rd_inv=1 and 1<=round<=Nr-1, the read data is InvMixColumns applied to each word of the stored key, for the equivalent inverse cipher. Rounds 0 and Nr are returned unmodified. Read latency is unchanged, with the transform placed before the output register.
- Undefined: the rk_rd_inv port and the transform logic are absent.

## Structure
- Package aes_pkg holds:
  - the key_len encoding constants
  - NK/NR lookup functions
  - the xtime function
  - the inv_mix_column function (used under the macro)
- Sub-module aes_sub_word: four instances of the existing registered forward S-box, with 32-bit input/output and 1-cycle latency. The single instance is shared by all SubWord steps.

## Test plan
- 128-bit key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - round 1 reads a0fafe17 88542cb1 23a33939 2a6c7605
  - round 10 reads d014f9a8 c9ee2589 e13f0cc8 b6630ca6
  - busy is high 50 cycles
- 192-bit key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - round 12 reads e98ba06f 448c773c 8ecc7204 01002202
  - busy is high 54 cycles
- 256-bit key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - round 14 reads fe4890d1 e6188d0b 046df344 706c631e
  - busy is high 65 cycles
- Handshake:
  - start pulsed mid-run is ignored and the result is unchanged
  - key_len=11 is ignored with busy staying 0
  - reading round 11 after a 128-bit run returns 0
- Reset: rst_n low at cycle 20 of a 256-bit run clears busy, done and keys_valid. A following 128-bit run then matches the vectors above.
- With AES_KEY_EXPAND_DEC_EN: a 128-bit round-1 read with rk_rd_inv=1 equals InvMixColumns(a0fafe17…) from the reference model, and round 0 and round 10 reads are unmodified.
